pred_table_ctrl: RTL and testbench

PRED_TABLE_CTRL -- requirements
Module: pred_table_ctrl

---
 rtl/pred_table_ctrl.sv | 139 +++++++++++++
 tb/tb_pred_table_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pred_table_ctrl.sv
// Branch prediction table controller: combinational lookup on RAM port 1, queued
// saturating-counter read-modify-write updates on RAM port 2.
module pred_table_ctrl #(
  parameter int unsigned LOGINDEX  = 8,
  parameter int unsigned CTRWIDTH  = 2,
  parameter int unsigned FIFODEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [LOGINDEX-1:0] lookup_index,
  output logic                pred_taken,
  input  logic                upd_valid,
  input  logic [LOGINDEX-1:0] upd_index,
  input  logic                upd_taken,
  output logic                upd_ready,
  output logic                busy,
  output logic                ram_we1,
  output logic [LOGINDEX-1:0] ram_index1,
  input  logic [CTRWIDTH-1:0] ram_rdata1,
  output logic                ram_we2,
  output logic [LOGINDEX-1:0] ram_index2,
  output logic [CTRWIDTH-1:0] ram_wdata2,
  input  logic [CTRWIDTH-1:0] ram_rdata2
);

  localparam int unsigned PtrW = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFODEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFODEPTH);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(FIFODEPTH - 1);
  localparam logic [CTRWIDTH-1:0] CtrMax = '1;

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [LOGINDEX-1:0] hold_index_q, hold_index_d;
  logic                hold_taken_q, hold_taken_d;
  logic [CTRWIDTH-1:0] new_ctr_q, new_ctr_d;
  logic [LOGINDEX-1:0] fifo_idx_q [FIFODEPTH];
  logic                fifo_tkn_q [FIFODEPTH];
  logic                push, pop;
  logic [CTRWIDTH-1:0] ctr_calc;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign ram_we1    = 1'b0;
  assign ram_index1 = lookup_index;
  assign ram_index2 = hold_index_q;
  assign ram_wdata2 = new_ctr_q;
  assign upd_ready  = (count_q < DepthCnt);
  assign push       = upd_valid && upd_ready;
  assign pop        = ((state_q == StIdle) || (state_q == StWr)) && (count_q != '0);
  assign busy       = (count_q != '0) || (state_q != StIdle);

  // Write bypass: the RAM still holds the old counter during the WR cycle.
  assign pred_taken = ((state_q == StWr) && (hold_index_q == lookup_index)) ?
                      new_ctr_q[CTRWIDTH-1] : ram_rdata1[CTRWIDTH-1];

  always_comb begin
    ctr_calc = ram_rdata2;
    if (hold_taken_q) begin
      if (ram_rdata2 != CtrMax) ctr_calc = ram_rdata2 + 1'b1;
    end else begin
      if (ram_rdata2 != '0) ctr_calc = ram_rdata2 - 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_index_d = hold_index_q;
    hold_taken_d = hold_taken_q;
    new_ctr_d    = new_ctr_q;
    ram_we2      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          hold_index_d = fifo_idx_q[rd_ptr_q];
          hold_taken_d = fifo_tkn_q[rd_ptr_q];
          state_d      = StRd;
        end
      end
      StRd: begin
        new_ctr_d = ctr_calc;
        state_d   = StWr;
      end
      StWr: begin
        ram_we2 = 1'b1;
        if (pop) begin
          hold_index_d = fifo_idx_q[rd_ptr_q];
          hold_taken_d = fifo_tkn_q[rd_ptr_q];
          state_d      = StRd;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hold_index_q <= '0;
      hold_taken_q <= 1'b0;
      new_ctr_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hold_index_q <= hold_index_d;
      hold_taken_q <= hold_taken_d;
      new_ctr_q    <= new_ctr_d;
    end
  end

  // Queue storage needs no reset; count and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx_q[wr_ptr_q] <= upd_index;
      fifo_tkn_q[wr_ptr_q] <= upd_taken;
    end
  end

endmodule

// File: tb/tb_pred_table_ctrl.sv
// Directed bench for pred_table_ctrl with a behavioural two-port counter RAM.
module tb_pred_table_ctrl;
  localparam int LI = 8;
  localparam int CW = 2;
  localparam int FD = 4;

  logic          clk, reset;
  logic [LI-1:0] lookup_index, upd_index, ram_index1, ram_index2;
  logic          pred_taken, upd_valid, upd_taken, upd_ready, busy, ram_we1, ram_we2;
  logic [CW-1:0] ram_rdata1, ram_rdata2, ram_wdata2;

  pred_table_ctrl #(.LOGINDEX(LI), .CTRWIDTH(CW), .FIFODEPTH(FD)) dut (
    .clk(clk), .reset(reset), .lookup_index(lookup_index), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .upd_ready(upd_ready), .busy(busy), .ram_we1(ram_we1), .ram_index1(ram_index1),
    .ram_rdata1(ram_rdata1), .ram_we2(ram_we2), .ram_index2(ram_index2),
    .ram_wdata2(ram_wdata2), .ram_rdata2(ram_rdata2)
  );

  // Behavioural RAM; cleared on reset, preloadable from the bench.
  logic [CW-1:0] tbl [2**LI];
  logic          ini_we;
  logic [LI-1:0] ini_idx;
  logic [CW-1:0] ini_val;
  assign ram_rdata1 = tbl[ram_index1];
  assign ram_rdata2 = tbl[ram_index2];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2**LI; i++) tbl[i] <= '0;
    end else if (ini_we) begin
      tbl[ini_idx] <= ini_val;
    end else if (ram_we2) begin
      tbl[ram_index2] <= ram_wdata2;
    end
  end

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int            wr_cyc [$];
  logic [LI-1:0] wr_idx [$];
  logic [CW-1:0] wr_dat [$];
  always @(negedge clk) begin
    if (ram_we2 && !reset) begin
      wr_cyc.push_back(cyc);
      wr_idx.push_back(ram_index2);
      wr_dat.push_back(ram_wdata2);
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp, n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_tbl(input logic [LI-1:0] idx, input logic [CW-1:0] val);
    @(negedge clk);
    ini_we = 1'b1; ini_idx = idx; ini_val = val;
    @(negedge clk);
    ini_we = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic clear_log();
    wr_cyc.delete(); wr_idx.delete(); wr_dat.delete();
  endtask

  typedef struct {
    logic [LI-1:0] idx;
    logic          tkn;
    logic [CW-1:0] init;
    logic [CW-1:0] exp_w;
  } vec_t;

  vec_t vecs [6];
  logic [8:0] exp_rdy;

  initial begin
    vecs[0] = '{idx: 8'd5,  tkn: 1'b1, init: 2'd1, exp_w: 2'd2};
    vecs[1] = '{idx: 8'd9,  tkn: 1'b1, init: 2'd3, exp_w: 2'd3};
    vecs[2] = '{idx: 8'd9,  tkn: 1'b0, init: 2'd0, exp_w: 2'd0};
    vecs[3] = '{idx: 8'd7,  tkn: 1'b1, init: 2'd1, exp_w: 2'd2};
    vecs[4] = '{idx: 8'd12, tkn: 1'b0, init: 2'd2, exp_w: 2'd1};
    vecs[5] = '{idx: 8'd40, tkn: 1'b0, init: 2'd3, exp_w: 2'd2};
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; ini_we = 1'b0; ini_idx = '0; ini_val = '0;
    upd_valid = 1'b0; upd_index = '0; upd_taken = 1'b0; lookup_index = '0;

    // Reset state
    #1;
    check("rst_we2", ram_we2, 1'b0);
    check("rst_we1", ram_we1, 1'b0);
    check("rst_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_ready", upd_ready, 1'b1);
    reset = 1'b0;

    // Single updates, including saturation and WR-cycle bypass
    foreach (vecs[v]) begin
      lookup_index = vecs[v].idx;
      set_tbl(vecs[v].idx, vecs[v].init);
      check($sformatf("v%0d_pred_pre", v), pred_taken, vecs[v].init[CW-1]);
      upd_valid = 1'b1; upd_index = vecs[v].idx; upd_taken = vecs[v].tkn;
      @(negedge clk);
      upd_valid = 1'b0;
      check($sformatf("v%0d_we_c1", v), ram_we2, 1'b0);
      @(negedge clk);
      check($sformatf("v%0d_we_c2", v), ram_we2, 1'b0);
      @(negedge clk);
      check($sformatf("v%0d_we_c3", v), ram_we2, 1'b1);
      check($sformatf("v%0d_idx", v), ram_index2, vecs[v].idx);
      check($sformatf("v%0d_wdata", v), ram_wdata2, vecs[v].exp_w);
      check($sformatf("v%0d_bypass", v), pred_taken, vecs[v].exp_w[CW-1]);
      check($sformatf("v%0d_we1", v), ram_we1, 1'b0);
      @(negedge clk);
      check($sformatf("v%0d_we_c4", v), ram_we2, 1'b0);
      check($sformatf("v%0d_busy_c4", v), busy, 1'b0);
      check($sformatf("v%0d_pred_post", v), pred_taken, vecs[v].exp_w[CW-1]);
    end

    // Full queue: 9 back-to-back requests; the 8th (index 27) finds the queue full
    wait_idle();
    for (int i = 0; i < 9; i++) set_tbl(LI'(20 + i), 2'd1);
    clear_log();
    exp_rdy = 9'b1_0111_1111;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("full_ready%0d", i), upd_ready, exp_rdy[i]);
      upd_valid = 1'b1; upd_index = LI'(20 + i); upd_taken = 1'b1;
      @(negedge clk);
    end
    upd_valid = 1'b0;
    wait_idle();
    check("full_nwr", wr_idx.size(), 8);
    if (wr_idx.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        check($sformatf("full_idx%0d", k), wr_idx[k], (k < 7) ? LI'(20 + k) : LI'(28));
        check($sformatf("full_dat%0d", k), wr_dat[k], 2'd2);
        if (k > 0) check($sformatf("full_gap%0d", k), wr_cyc[k] - wr_cyc[k-1], 2);
      end
    end

    // Same-index chain must see each preceding write
    set_tbl(8'd3, 2'd0);
    clear_log();
    for (int i = 0; i < 3; i++) begin
      upd_valid = 1'b1; upd_index = 8'd3; upd_taken = 1'b1;
      @(negedge clk);
    end
    upd_valid = 1'b0;
    wait_idle();
    check("chain_nwr", wr_idx.size(), 3);
    if (wr_idx.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("chain_idx%0d", k), wr_idx[k], 8'd3);
        check($sformatf("chain_dat%0d", k), wr_dat[k], k + 1);
      end
    end

    // Reset while in RD with another entry still queued
    clear_log();
    upd_valid = 1'b1; upd_index = 8'd50; upd_taken = 1'b1;
    @(negedge clk);
    upd_index = 8'd51;
    @(negedge clk);
    upd_valid = 1'b0;
    check("rd_busy", busy, 1'b1);
    check("rd_we2", ram_we2, 1'b0);
    reset = 1'b1;
    #1;
    check("rstrd_we2", ram_we2, 1'b0);
    check("rstrd_busy", busy, 1'b0);
    check("rstrd_ready", upd_ready, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("rstrd_nwr", wr_idx.size(), 0);
    check("rstrd_busy_after", busy, 1'b0);
    check("rstrd_ready_after", upd_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
